// File: rtl/pitrex_via_pkg.sv
// Shared VIA command types for the PiTrex bus path.
// Used by the command queue and the Vectrex bus stage.
package pitrex_via_pkg;

  localparam int VIA_ADDR_W = 4;
  localparam int VIA_DATA_W = 8;

  // Chip-select base of the VIA in the Vectrex map; decoded by the bus stage.
  localparam logic [15:0] VIA_CS_BASE = 16'hD000;

  typedef struct packed {
    logic                  read;
    logic [VIA_ADDR_W-1:0] addr;
    logic [VIA_DATA_W-1:0] data;
  } via_cmd_t;

  // Reads carry no payload; the bus stage must see zero data for them.
  function automatic via_cmd_t via_cmd_mask(input via_cmd_t c);
    via_cmd_t r;
    r = c;
    if (c.read) begin
      r.data = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/pitrex_sync_fifo.sv
// Single-clock first-word-fall-through FIFO of VIA commands.
// Pointers carry one extra wrap bit to separate full from empty.
module pitrex_sync_fifo
  import pitrex_via_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  via_cmd_t      i_cmd,
  output logic          o_full,
  input  logic          i_pop,
  output logic          o_empty,
  output via_cmd_t      o_head,
  output logic [PW-1:0] o_level
);

  via_cmd_t mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          push_ok;
  logic          pop_ok;

  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0])
                && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // Full is taken from registered pointers only, so a same-cycle pop
  // never makes room for a push.
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;

  assign o_head  = mem_q[rd_ptr_q[AW-1:0]];
  assign o_level = wr_ptr_q - rd_ptr_q;

  // Pointer advance; natural wrap of the PW-bit counters is modulo 2*DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  // Pointer registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= i_cmd;
    end
  end

endmodule

// File: rtl/via_cmd_queue.sv
// Pi-side VIA command queue and single-entry read response register.
// Define VIA_CMD_QUEUE_STATS_EN to add the o_high_water occupancy output.
module via_cmd_queue
  import pitrex_via_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = VIA_ADDR_W,
  parameter int DATA_W = VIA_DATA_W,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  output logic              o_push_ready,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_data,
  input  logic              i_cmd_read,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_via_addr,
  output logic [DATA_W-1:0] o_via_data,
  output logic              o_via_read,
  input  logic              i_load,
  input  logic              i_rd_stb,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_data,
  input  logic              i_rsp_ack,
`ifdef VIA_CMD_QUEUE_STATS_EN
  output logic [LW-1:0]     o_high_water,
`endif
  output logic [LW-1:0]     o_level,
  output logic              o_overflow,
  output logic              o_rsp_overrun
);

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] ONE_L   = LW'(1);

  via_cmd_t cmd_in;
  via_cmd_t head;
  via_cmd_t head_vis;
  logic     full;
  logic     empty;

  logic [LW-1:0]     outst_q, outst_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              overflow_q, overflow_d;
  logic              overrun_q, overrun_d;
  logic              rd_pop;
  logic              rd_take;

  assign cmd_in.read = i_cmd_read;
  assign cmd_in.addr = i_cmd_addr;
  assign cmd_in.data = i_cmd_data;

  pitrex_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_push),
    .i_cmd   (cmd_in),
    .o_full  (full),
    .i_pop   (i_load),
    .o_empty (empty),
    .o_head  (head),
    .o_level (o_level)
  );

  assign o_push_ready = !full;
  assign o_valid      = !empty;

  // Bus-facing head is zeroed when empty and data-masked for reads.
  assign head_vis   = empty ? '0 : via_cmd_mask(head);
  assign o_via_addr = head_vis.addr;
  assign o_via_data = head_vis.data;
  assign o_via_read = head_vis.read;

  // A strobe only counts while some popped read is still unanswered.
  assign rd_pop  = i_load && !empty && head.read;
  assign rd_take = i_rd_stb && (outst_q != '0);

  // Outstanding-read bookkeeping, saturating at DEPTH.
  always_comb begin
    outst_d = outst_q;
    unique case ({rd_pop, rd_take})
      2'b10: begin
        if (outst_q != DEPTH_L) begin
          outst_d = outst_q + ONE_L;
        end
      end
      2'b01:   outst_d = outst_q - ONE_L;
      default: outst_d = outst_q;
    endcase
  end

  // Response capture, ack and sticky error flags.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    overrun_d   = overrun_q;
    overflow_d  = overflow_q | (i_push && full);
    if (rd_take) begin
      rsp_data_d  = i_rd_data;
      rsp_valid_d = 1'b1;
      if (rsp_valid_q && !i_rsp_ack) begin
        overrun_d = 1'b1;
      end
    end else if (i_rsp_ack) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Response and status registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      outst_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      overflow_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      outst_q     <= outst_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      overflow_q  <= overflow_d;
      overrun_q   <= overrun_d;
    end
  end

  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_data    = rsp_data_q;
  assign o_overflow    = overflow_q;
  assign o_rsp_overrun = overrun_q;

`ifdef VIA_CMD_QUEUE_STATS_EN
  logic [LW-1:0] hw_q, hw_d;

  // Peak occupancy tracker; trails o_level by one cycle.
  always_comb begin
    hw_d = hw_q;
    if (o_level > hw_q) begin
      hw_d = (o_level > DEPTH_L) ? DEPTH_L : o_level;
    end
  end

  // High-water register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hw_q <= '0;
    end else begin
      hw_q <= hw_d;
    end
  end

  assign o_high_water = hw_q;
`endif

endmodule
